addr_gen_stage: RTL and testbench

Pipelined, parametrised successor to the combinational address builder. The stage accepts one decoded instruction per cycle over a valid/ready handshake. It resolves jump/branch redirects and load/store addresses, and registers the result for the next stage. It also adds the following behaviour:
- misalignment and illegal-funct3 detection;
- byte-enable and store-data lane alignment;
- a squash counter that kills the wrong-path instructions accepted after a taken redirect.

It sits between decode/register-read and the IFU/memory interface.

---
 rtl/addr_gen_stage.sv | 208 ++++++++++++++++++++
 tb/tb_addr_gen_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/addr_gen_stage.sv
// Address generation stage: resolves jump/branch redirects and load/store addresses,
// registers the result behind a valid/ready handshake and squashes wrong-path beats.
module addr_gen_stage #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc,
    input  logic [5:0]        ccr_flags,
    input  logic [XLEN-1:0]   rs1data,
    input  logic [XLEN-1:0]   rs2data,
    input  logic [2:0]        funct3,
    input  logic [6:0]        opcode,
    input  logic [XLEN-1:0]   imm_ext,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        pc_sel,
    output logic [XLEN-1:0]   pc_ab,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              misalign,
    output logic              illegal
);
    // state  | meaning
    // IDLE   | count == 0, accepted beats are live
    // SQUASH | count  > 0, accepted beats are killed and count decrements

    localparam int BW     = XLEN / 8;
    localparam int LANE_W = $clog2(BW);

    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] SEL_PC4 = 2'b01;
    localparam logic [1:0] SEL_ARB = 2'b10;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

    logic [2:0]        count;
    logic [0:0]        state;
    logic              accept;
    logic              kill;
    logic              live;

    logic [XLEN-1:0]   sum_pc;
    logic [XLEN-1:0]   sum_rs;
    logic [XLEN-1:0]   jalr_tgt;
    logic [LANE_W-1:0] off;
    logic [BW-1:0]     mask;
    logic              br_flag;
    logic              ls_misal;
    logic              ld_bad;
    logic              st_bad;

    logic [1:0]        n_pc_sel;
    logic [XLEN-1:0]   n_pc_ab;
    logic [XLEN-1:0]   n_mem_addr;
    logic [XLEN-1:0]   n_mem_wdata;
    logic [BW-1:0]     n_mem_be;
    logic              n_mem_rd;
    logic              n_mem_wr;
    logic              n_misalign;
    logic              n_illegal;

    assign state    = (count != 3'd0) ? ST_SQUASH : ST_IDLE;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign kill     = accept && (state == ST_SQUASH);
    assign live     = accept && (state == ST_IDLE);

    assign sum_pc   = pc + imm_ext;
    assign sum_rs   = rs1data + imm_ext;
    assign jalr_tgt = sum_rs & ~XLEN'(1);
    assign off      = sum_rs[LANE_W-1:0];

    // funct3[1:0] encodes access size for both loads and stores
    assign ls_misal = ((funct3[1:0] == 2'b01) && sum_rs[0]) ||
                      ((funct3[1:0] == 2'b10) && (sum_rs[1:0] != 2'b00));
    assign ld_bad   = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
    assign st_bad   = funct3[2] || (funct3[1:0] == 2'b11);

    always_comb begin
        mask = BW'(4'h1);
        case (funct3[1:0])
            2'b01:   mask = BW'(4'h3);
            2'b10:   mask = BW'(4'hF);
            default: mask = BW'(4'h1);
        endcase
    end

    always_comb begin
        br_flag = 1'b0;
        case (funct3)
            3'b000:  br_flag = ccr_flags[5];
            3'b001:  br_flag = ccr_flags[4];
            3'b100:  br_flag = ccr_flags[3];
            3'b101:  br_flag = ccr_flags[2];
            3'b110:  br_flag = ccr_flags[1];
            3'b111:  br_flag = ccr_flags[0];
            default: br_flag = 1'b0;
        endcase
    end

    always_comb begin
        n_pc_sel    = SEL_PC4;
        n_pc_ab     = '0;
        n_mem_addr  = '0;
        n_mem_wdata = '0;
        n_mem_be    = '0;
        n_mem_rd    = 1'b0;
        n_mem_wr    = 1'b0;
        n_misalign  = 1'b0;
        n_illegal   = 1'b0;
        case (opcode)
            OP_J: begin
                n_pc_ab = sum_pc;
                if (sum_pc[1:0] != 2'b00) n_misalign = 1'b1;
                else                      n_pc_sel   = SEL_ARB;
            end
            OP_JALR: begin
                n_pc_ab = jalr_tgt;
                if (jalr_tgt[1:0] != 2'b00) n_misalign = 1'b1;
                else                        n_pc_sel   = SEL_ARB;
            end
            OP_B: begin
                n_pc_ab = sum_pc;
                if (funct3[2:1] == 2'b01) begin
                    n_illegal = 1'b1;
                end else if (br_flag) begin
                    if (sum_pc[1:0] != 2'b00) n_misalign = 1'b1;
                    else                      n_pc_sel   = SEL_ARB;
                end
            end
            OP_LOAD: begin
                n_mem_addr = sum_rs;
                if (ld_bad) begin
                    n_illegal = 1'b1;
                end else begin
                    n_mem_be = mask << off;
                    if (ls_misal) n_misalign = 1'b1;
                    else          n_mem_rd   = 1'b1;
                end
            end
            OP_STORE: begin
                n_mem_addr = sum_rs;
                if (st_bad) begin
                    n_illegal = 1'b1;
                end else begin
                    n_mem_be    = mask << off;
                    n_mem_wdata = rs2data << {off, 3'b000};
                    if (ls_misal) n_misalign = 1'b1;
                    else          n_mem_wr   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 3'd0;
            out_valid <= 1'b0;
            pc_sel    <= 2'b00;
            pc_ab     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            misalign  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            // killed beats only count down; they never restart the squash window
            if (kill)
                count <= count - 3'd1;
            else if (live && (n_pc_sel == SEL_ARB))
                count <= FLUSH_LD;

            if (live) begin
                out_valid <= 1'b1;
                pc_sel    <= n_pc_sel;
                pc_ab     <= n_pc_ab;
                mem_addr  <= n_mem_addr;
                mem_wdata <= n_mem_wdata;
                mem_be    <= n_mem_be;
                mem_rd    <= n_mem_rd;
                mem_wr    <= n_mem_wr;
                misalign  <= n_misalign;
                illegal   <= n_illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_addr_gen_stage.sv
// Directed bench for addr_gen_stage (XLEN=32, FLUSH_CYCLES=2) with hand-computed expectations.
module tb_addr_gen_stage;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [5:0]  ccr_flags;
    logic [31:0] rs1data;
    logic [31:0] rs2data;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
    logic [31:0] imm_ext;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  pc_sel;
    logic [31:0] pc_ab;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rd;
    logic        mem_wr;
    logic        misalign;
    logic        illegal;

    int n_checks = 0;
    int n_pass   = 0;

    addr_gen_stage #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .ccr_flags(ccr_flags), .rs1data(rs1data), .rs2data(rs2data),
        .funct3(funct3), .opcode(opcode), .imm_ext(imm_ext),
        .out_valid(out_valid), .out_ready(out_ready), .pc_sel(pc_sel), .pc_ab(pc_ab),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .misalign(misalign), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic beat(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                        input logic [5:0] ccr);
        in_valid  = 1'b1;
        opcode    = opc;
        funct3    = f3;
        pc        = p;
        rs1data   = r1;
        rs2data   = r2;
        imm_ext   = imm;
        ccr_flags = ccr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pc = '0; ccr_flags = '0; rs1data = '0; rs2data = '0;
        funct3 = '0; opcode = '0; imm_ext = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pc_sel", pc_sel, 0);
        chk("rst_pc_ab", pc_ab, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // BEQ taken, two killed beats, third beat live
        beat(OP_B, 3'b000, 32'h100, 0, 0, 32'h20, 6'b100000);
        tick();
        chk("beq_valid", out_valid, 1);
        chk("beq_pc_sel", pc_sel, 2'b10);
        chk("beq_pc_ab", pc_ab, 32'h120);
        beat(OP_ALU, 3'b000, 32'h104, 0, 0, 0, 0);
        tick();
        chk("kill1_valid", out_valid, 0);
        chk("kill1_hold_pc_ab", pc_ab, 32'h120);
        beat(OP_ALU, 3'b000, 32'h108, 0, 0, 0, 0);
        tick();
        chk("kill2_valid", out_valid, 0);
        beat(OP_LOAD, 3'b010, 32'h10C, 32'h3000, 0, 32'h4, 0);
        tick();
        chk("post_squash_valid", out_valid, 1);
        chk("post_squash_addr", mem_addr, 32'h3004);
        chk("post_squash_rd", mem_rd, 1);
        chk("post_squash_be", mem_be, 4'hF);

        // unaligned JALR: misalign, no redirect, no squash
        beat(OP_JALR, 3'b000, 32'h200, 32'h1003, 0, 0, 0);
        tick();
        chk("jalr_pc_ab", pc_ab, 32'h1002);
        chk("jalr_misalign", misalign, 1);
        chk("jalr_pc_sel", pc_sel, 2'b01);
        beat(OP_ALU, 3'b000, 32'h204, 0, 0, 0, 0);
        tick();
        chk("jalr_no_squash", out_valid, 1);
        chk("alu_pc_sel", pc_sel, 2'b01);
        chk("alu_misalign", misalign, 0);

        // SB / SH lane shifts
        beat(OP_STORE, 3'b000, 32'h208, 32'h2001, 32'hAB, 32'h2, 0);
        tick();
        chk("sb_addr", mem_addr, 32'h2003);
        chk("sb_be", mem_be, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hAB00_0000);
        chk("sb_wr", mem_wr, 1);
        chk("sb_rd", mem_rd, 0);
        beat(OP_STORE, 3'b001, 32'h20C, 32'h2000, 32'h1234, 32'h2, 0);
        tick();
        chk("sh_be", mem_be, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'h1234_0000);
        chk("sh_wr", mem_wr, 1);

        // misaligned LW, illegal load/store funct3
        beat(OP_LOAD, 3'b010, 32'h210, 32'h2000, 0, 32'h2, 0);
        tick();
        chk("lw_mis_misalign", misalign, 1);
        chk("lw_mis_rd", mem_rd, 0);
        beat(OP_LOAD, 3'b011, 32'h214, 32'h2000, 0, 0, 0);
        tick();
        chk("ld_ill_illegal", illegal, 1);
        chk("ld_ill_be", mem_be, 0);
        chk("ld_ill_rd", mem_rd, 0);
        beat(OP_STORE, 3'b100, 32'h218, 32'h2000, 32'h55, 0, 0);
        tick();
        chk("st_ill_illegal", illegal, 1);
        chk("st_ill_wr", mem_wr, 0);

        // branch not taken and illegal branch funct3
        beat(OP_B, 3'b001, 32'h300, 0, 0, 32'h40, 6'b100000);
        tick();
        chk("bne_nt_pc_sel", pc_sel, 2'b01);
        chk("bne_nt_pc_ab", pc_ab, 32'h340);
        beat(OP_B, 3'b010, 32'h304, 0, 0, 32'h40, 6'b111111);
        tick();
        chk("b010_valid", out_valid, 1);
        chk("b010_illegal", illegal, 1);
        chk("b010_pc_sel", pc_sel, 2'b01);

        // J taken; a killed taken branch must not reload the counter
        beat(OP_J, 3'b000, 32'h400, 0, 0, 32'h100, 0);
        tick();
        chk("j_pc_sel", pc_sel, 2'b10);
        chk("j_pc_ab", pc_ab, 32'h500);
        beat(OP_B, 3'b000, 32'h404, 0, 0, 32'h40, 6'b100000);
        tick();
        chk("j_kill1_valid", out_valid, 0);
        chk("j_kill1_pc_ab", pc_ab, 32'h500);
        beat(OP_ALU, 3'b000, 32'h408, 0, 0, 0, 0);
        tick();
        chk("j_kill2_valid", out_valid, 0);
        beat(OP_ALU, 3'b000, 32'h40C, 0, 0, 0, 0);
        tick();
        chk("j_no_reload_valid", out_valid, 1);
        chk("j_no_reload_pc_sel", pc_sel, 2'b01);

        // BLTU taken with negative offset, then reset with count=1
        beat(OP_B, 3'b110, 32'h200, 0, 0, 32'hFFFF_FFF8, 6'b000010);
        tick();
        chk("bltu_pc_ab", pc_ab, 32'h1F8);
        chk("bltu_pc_sel", pc_sel, 2'b10);
        beat(OP_ALU, 3'b000, 32'h204, 0, 0, 0, 0);
        tick();
        chk("bltu_kill_valid", out_valid, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_pc_ab", pc_ab, 0);
        chk("rst_async_pc_sel", pc_sel, 0);
        rst_n = 1'b1;
        beat(OP_ALU, 3'b000, 32'h208, 0, 0, 0, 0);
        tick();
        chk("post_rst_not_killed", out_valid, 1);

        // backpressure then release
        beat(OP_LOAD, 3'b010, 32'h500, 32'h10, 0, 0, 0);
        tick();
        chk("bp_first_addr", mem_addr, 32'h10);
        out_ready = 1'b0;
        beat(OP_LOAD, 3'b010, 32'h504, 32'h14, 0, 0, 0);
        #1;
        chk("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_addr", mem_addr, 32'h10);
            chk("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_addr", mem_addr, 32'h14);
        beat(OP_LOAD, 3'b010, 32'h508, 32'h18, 0, 0, 0);
        tick();
        chk("bp_third_addr", mem_addr, 32'h18);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_hold_addr", mem_addr, 32'h18);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
